servo_frame_sched: RTL and testbench
====================================

# servo_frame_sched

Frame scheduler that turns the 40 kHz divider tick into staggered servo PWM pulses for up to NUM_CH channels. Each frame of FRAME_TICKS ticks (20 ms) is split into per-channel slots. Each channel emits one pulse of its commanded width at the start of its slot. Width commands arrive over a valid/ready port and take effect together at the next frame boundary. The block sits between the SPI command decoder and the servo output pins.

## Interface
- NUM_CH, 4: number of servo channels (2..8).
- FRAME_TICKS, 800: ticks per frame (20 ms at 40 kHz).
- SLOT_TICKS, 100: ticks per channel slot; NUM_CH*SLOT_TICKS <= FRAME_TICKS required.
- MIN_TICKS, 40: minimum pulse width (1.0 ms).
- MAX_TICKS, 80: maximum pulse width (2.0 ms); MAX_TICKS < SLOT_TICKS required.
- DEFAULT_TICKS, 60: width loaded at reset (1.5 ms, centre).
- clk  in  1  system clock, 100 MHz; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk enable pulse from the clock divider; all timing advances only on tick.
- en  in  1  run enable.
- cmd_valid  in  1  width command valid.
- cmd_ready  out  1  command can be accepted (combinational).
- cmd_ch  in  clog2(NUM_CH)  target channel.
- cmd_width  in  8  requested width in ticks.
- cmd_clamped  out  1  one-clk pulse: the last accepted command was clamped.
- servo_pwm  out  NUM_CH  registered PWM outputs.
- frame_start  out  1  one-clk pulse on each frame commit edge.

## Operation
- Per channel: active width act[k], pending width pend[k], flag pv[k].
- Command handshake:
  - cmd_ready = !pv[cmd_ch]; a channel holds at most one pending value.
  - Accept when cmd_valid && cmd_ready: pend[cmd_ch] <= clamp(cmd_width, MIN_TICKS, MAX_TICKS); pv[cmd_ch] <= 1.
  - cmd_clamped pulses the next cycle if cmd_width was clamped.
  - cmd_ch >= NUM_CH: command accepted and discarded; no clamp pulse.
- Commit on the frame_start edge: for every k with pv[k]=1, act[k] <= pend[k] and pv[k] <= 0.
  - A command accepted on the commit edge itself is stored as pending; its pv stays 1 and it applies at the next frame.
- FSM states: IDLE, PULSE, GAP, TAIL. Counters: ch (channel index), wcnt (width countdown), scnt (slot tick count), fcnt (frame tick count).
- IDLE: all outputs 0, fcnt=0. On tick && en: commit, frame_start=1, ch=0, wcnt=act[0], scnt=0 -> PULSE.
- PULSE: servo_pwm[ch]=1. Each tick: scnt++, wcnt--; when wcnt reaches 0 -> GAP.
- GAP: all servo_pwm 0. On the tick where scnt reaches SLOT_TICKS:
  - if ch < NUM_CH-1: ch++, scnt=0, wcnt=act[ch] -> PULSE;
  - otherwise -> TAIL.
- TAIL: on the tick where fcnt reaches FRAME_TICKS:
  - if en: fcnt=0, commit, frame_start -> PULSE with ch=0;
  - else -> IDLE.
- fcnt increments on every tick outside IDLE.
- en deasserted mid-frame: the current frame completes unchanged (no truncated pulse), then IDLE.
- At most one servo_pwm bit is high at any time.

## Timing
- Reset values: servo_pwm=0, frame_start=0, cmd_clamped=0, act[k]=DEFAULT_TICKS, pv=0, state IDLE, all counters 0.
- Reset is asynchronous: asserting rst_n mid-pulse drops servo_pwm on assertion, without waiting for a clk edge.
- Latency:
  - The edge sampling the starting tick sets servo_pwm[ch].
  - The edge sampling the width-th following tick clears it, so the pulse lasts exactly width tick periods.
- Pulse for channel k rises at frame tick k*SLOT_TICKS.
- Frame period is exactly FRAME_TICKS tick periods, back to back.
- tick held high for more than one clk is treated as one tick per clk; the bench drives single-cycle ticks only.
- Between ticks, only the command port and cmd_clamped change.

## Test plan
- Reset, en=1, no commands -> servo_pwm[0..3] each 60 ticks high, rising at frame ticks 0/100/200/300; frame_start every 800 ticks.
- Command ch=2, width 75 mid-frame -> channel 2 stays at 60 for the rest of that frame, is 75 from the next frame, and cmd_ready for ch2 is low until the commit.
- Command widths 10 and 200 -> clamped to 40 and 80; cmd_clamped pulses once per command; width 50 -> no pulse.
- Command accepted on the frame_start edge -> not applied in the new frame, applied one frame later; pv remains 1 across the boundary.
- en dropped during the channel 1 pulse -> channel 1 full width, channels 2 and 3 still pulse, then IDLE with no frame_start at tick 800; en raised again -> new frame starts on the next tick.
- rst_n asserted mid-pulse -> servo_pwm=0 immediately; after release, widths are 60 and pending commands are lost.

Source files
------------

// File: rtl/servo_frame_sched.sv
// Staggered servo PWM frame scheduler: one pulse per channel slot per frame,
// width commands staged as pending and committed together at each frame start.

module servo_frame_ch #(
    parameter int DEFAULT_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       commit,
    input  logic       load,
    input  logic [7:0] load_width,
    output logic [7:0] width,
    output logic       pv
);
    logic [7:0] act;
    logic [7:0] pend;

    // Width a pulse starting this cycle must use: the pending value wins on a commit edge.
    assign width = (commit && pv) ? pend : act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act  <= 8'(DEFAULT_TICKS);
            pend <= 8'(DEFAULT_TICKS);
            pv   <= 1'b0;
        end else begin
            if (commit && pv) begin
                act <= pend;
                pv  <= 1'b0;
            end
            if (load) begin
                pend <= load_width;
                pv   <= 1'b1;
            end
        end
    end
endmodule

module servo_frame_sched #(
    parameter int NUM_CH        = 4,
    parameter int FRAME_TICKS   = 800,
    parameter int SLOT_TICKS    = 100,
    parameter int MIN_TICKS     = 40,
    parameter int MAX_TICKS     = 80,
    parameter int DEFAULT_TICKS = 60
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      en,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
    input  logic [7:0]                cmd_width,
    output logic                      cmd_clamped,
    output logic [NUM_CH-1:0]         servo_pwm,
    output logic                      frame_start
);
    localparam int CW = $clog2(NUM_CH);
    localparam int SW = $clog2(SLOT_TICKS + 1);
    localparam int FW = $clog2(FRAME_TICKS + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_TICKS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [CW-1:0] CH_LAST    = CW'(NUM_CH - 1);
    localparam logic [7:0]    MIN_W      = 8'(MIN_TICKS);
    localparam logic [7:0]    MAX_W      = 8'(MAX_TICKS);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, TAIL} state_t;

    state_t                   state, state_d;
    logic [CW-1:0]            ch, ch_d, ch_inc;
    logic [7:0]               wcnt, wcnt_d;
    logic [SW-1:0]            scnt, scnt_d;
    logic [FW-1:0]            fcnt, fcnt_d;
    logic [NUM_CH-1:0]        pwm_d;
    logic [NUM_CH-1:0][7:0]   width;
    logic [NUM_CH-1:0]        pv;
    logic [NUM_CH-1:0]        load;
    logic                     ch_ok, sel_pv, accept, clamp_hit;
    logic [7:0]               clamp_w;
    logic                     frame_end, go;

    // Channel indices beyond NUM_CH are always ready and simply dropped.
    always_comb begin
        ch_ok  = 1'b0;
        sel_pv = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cmd_ch == CW'(k)) begin
                ch_ok  = 1'b1;
                sel_pv = pv[k];
            end
        end
    end

    assign cmd_ready = !sel_pv;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        clamp_w   = cmd_width;
        clamp_hit = 1'b0;
        if (cmd_width < MIN_W) begin
            clamp_w   = MIN_W;
            clamp_hit = 1'b1;
        end else if (cmd_width > MAX_W) begin
            clamp_w   = MAX_W;
            clamp_hit = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign load[k] = accept && (cmd_ch == CW'(k));
        servo_frame_ch #(.DEFAULT_TICKS(DEFAULT_TICKS)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .commit     (go),
            .load       (load[k]),
            .load_width (clamp_w),
            .width      (width[k]),
            .pv         (pv[k])
        );
    end

    // Frame wrap can land in GAP when the last slot ends exactly on the frame boundary.
    assign frame_end = tick && (fcnt == FRAME_LAST) &&
                       ((state == TAIL) ||
                        (state == GAP && scnt == SLOT_LAST && ch == CH_LAST));
    assign go        = en && ((state == IDLE && tick) || frame_end);
    assign ch_inc    = ch + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch          <= '0;
            wcnt        <= '0;
            scnt        <= '0;
            fcnt        <= '0;
            servo_pwm   <= '0;
            frame_start <= 1'b0;
            cmd_clamped <= 1'b0;
        end else begin
            state       <= state_d;
            ch          <= ch_d;
            wcnt        <= wcnt_d;
            scnt        <= scnt_d;
            fcnt        <= fcnt_d;
            servo_pwm   <= pwm_d;
            frame_start <= go;
            cmd_clamped <= accept && ch_ok && clamp_hit;
        end
    end

    always_comb begin
        state_d = state;
        ch_d    = ch;
        wcnt_d  = wcnt;
        scnt_d  = scnt;
        fcnt_d  = fcnt;
        case (state)
            IDLE: fcnt_d = '0;
            PULSE: if (tick) begin
                fcnt_d = fcnt + 1'b1;
                scnt_d = scnt + 1'b1;
                wcnt_d = wcnt - 1'b1;
                if (wcnt == 8'd1) state_d = GAP;
            end
            GAP: if (tick) begin
                fcnt_d = fcnt + 1'b1;
                scnt_d = scnt + 1'b1;
                if (scnt == SLOT_LAST) begin
                    if (ch != CH_LAST) begin
                        ch_d    = ch_inc;
                        scnt_d  = '0;
                        wcnt_d  = width[ch_inc];
                        state_d = PULSE;
                    end else if (frame_end) begin
                        fcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: if (tick) begin
                fcnt_d = fcnt + 1'b1;
                if (frame_end) begin
                    fcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (go) begin
            state_d = PULSE;
            ch_d    = '0;
            scnt_d  = '0;
            fcnt_d  = '0;
            wcnt_d  = width[0];
        end
    end

    always_comb begin
        pwm_d = '0;
        if (state_d == PULSE) pwm_d[ch_d] = 1'b1;
    end
endmodule

// File: tb/tb_servo_frame_sched.sv
// Scoreboard bench for servo_frame_sched: a frame-level model queues expected
// pulses and frame starts; a monitor pops and compares them as the DUT emits.
module tb_servo_frame_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       en = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_ch = '0;
    logic [7:0] cmd_width = '0;
    logic       cmd_clamped;
    logic [3:0] servo_pwm;
    logic       frame_start;

    servo_frame_sched dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_width(cmd_width), .cmd_clamped(cmd_clamped),
        .servo_pwm(servo_pwm), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; int rise; int width;} pulse_t;
    pulse_t pq[$];
    int     fq[$];
    int     total = 0;
    int     bad = 0;
    int     tcnt = 0;
    bit     tick_on = 1'b0;
    int     mact[4];
    int     mpend[4];
    bit     mpv[4];
    bit     mrun, mgo;
    int     mft, m_start;
    int     rise_t[4];
    logic [3:0] prev = '0;
    pulse_t mp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int clampw(input int w);
        return (w < 40) ? 40 : ((w > 80) ? 80 : w);
    endfunction

    // Single-clk ticks, one every second clk.
    initial forever begin
        @(negedge clk);
        tick = tick_on && !tick;
    end

    // Frame-level reference model.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin mact[k] = 60; mpv[k] = 1'b0; end
            mrun = 1'b0; mft = 0;
            pq.delete(); fq.delete();
        end else begin
            if (tick) begin
                mgo = 1'b0;
                if (!mrun) mgo = en;
                else begin
                    mft++;
                    if (mft == 800) begin
                        if (en) mgo = 1'b1; else mrun = 1'b0;
                    end
                end
                if (mgo) begin
                    for (int k = 0; k < 4; k++)
                        if (mpv[k]) begin mact[k] = mpend[k]; mpv[k] = 1'b0; end
                    mrun = 1'b1; mft = 0; m_start = tcnt;
                    fq.push_back(tcnt);
                    for (int k = 0; k < 4; k++) pq.push_back('{k, tcnt + k*100, mact[k]});
                end
                tcnt++;
            end
            if (cmd_valid && !mpv[cmd_ch]) begin
                mpend[cmd_ch] = clampw(int'(cmd_width));
                mpv[cmd_ch]   = 1'b1;
            end
        end
    end

    // Output monitor.
    initial forever begin
        @(negedge clk);
        if (!rst_n) prev = '0;
        else begin
            if ($countones(servo_pwm) > 1) chk("onehot", $countones(servo_pwm), 1);
            if (frame_start === 1'b1) begin
                if (fq.size() == 0) chk("fs_unexpected", tcnt - 1, -1);
                else chk("fs_tick", tcnt - 1, fq.pop_front());
            end
            for (int k = 0; k < 4; k++) begin
                if (servo_pwm[k] && !prev[k]) rise_t[k] = tcnt - 1;
                if (!servo_pwm[k] && prev[k]) begin
                    if (pq.size() == 0) chk("pwm_unexpected", k, -1);
                    else begin
                        mp = pq.pop_front();
                        chk("pwm_ch", k, mp.ch);
                        chk("pwm_rise", rise_t[k], mp.rise);
                        chk("pwm_width", tcnt - 1 - rise_t[k], mp.width);
                    end
                end
            end
            prev = servo_pwm;
        end
    end

    task automatic wait_tcnt(input int t);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk); #1;
            if (tcnt >= t) return;
        end
        chk("wait_timeout", tcnt, t);
    endtask

    task automatic at_tick_edge(input int t);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk); #1;
            if (tick && tcnt == t) return;
        end
        chk("edge_timeout", tcnt, t);
    endtask

    task automatic peek_ready(input int ch, input int exp, input string tag);
        cmd_valid = 1'b0;
        cmd_ch    = 2'(ch);
        #1;
        chk(tag, cmd_ready, exp);
    endtask

    task automatic send_cmd(input int ch, input int w, input string tag);
        int exp_cl;
        exp_cl    = (w < 40 || w > 80) ? 1 : 0;
        cmd_ch    = 2'(ch);
        cmd_width = 8'(w);
        cmd_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, cmd_ready, 1);
        @(negedge clk); #1;
        chk({tag, "_clamp"}, cmd_clamped, exp_cl);
        cmd_valid = 1'b0;
        @(negedge clk); #1;
        chk({tag, "_clamp_off"}, cmd_clamped, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog tcnt=%0d", tcnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pwm", servo_pwm, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_clamp", cmd_clamped, 0);
        peek_ready(2, 1, "rst_rdy");
        rst_n = 1'b1; en = 1'b1; tick_on = 1'b1;

        // Frame 1: defaults; commands land mid-frame and wait for the next commit.
        wait_tcnt(150);
        send_cmd(2, 75, "c2w75");
        peek_ready(2, 0, "c2_pend_rdy");
        send_cmd(1, 10, "c1w10");
        send_cmd(3, 200, "c3w200");
        send_cmd(0, 50, "c0w50");
        wait_tcnt(810);
        peek_ready(2, 1, "c2_commit_rdy");

        // Command accepted on the commit edge of frame 3 applies in frame 4.
        at_tick_edge(m_start + 800);
        send_cmd(1, 70, "edge_c1w70");
        peek_ready(1, 0, "edge_pv_held");

        // Drop en during channel 1 pulse of frame 4.
        wait_tcnt(m_start + 920);
        en = 1'b0;
        s = m_start;
        wait_tcnt(s + 810);
        chk("idle_pwm", servo_pwm, 0);
        en = 1'b1;

        // New frame, pending command then async reset mid channel 0 pulse.
        wait_tcnt(tcnt + 5);
        s = m_start;
        send_cmd(3, 45, "c3w45");
        wait_tcnt(s + 20);
        chk("pre_rst_pwm0", servo_pwm[0], 1);
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", servo_pwm, 0);
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b1;
        peek_ready(3, 1, "rst_lost_pend");

        // One full frame with reset widths, then drain to idle.
        wait_tcnt(tcnt + 10);
        en = 1'b0;
        s = m_start;
        wait_tcnt(s + 820);
        chk("pq_empty", pq.size(), 0);
        chk("fq_empty", fq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
